dmem_mmio: RTL and testbench

- Data-side slave directly downstream of the single-cycle RV32I core.
- Consumes the core's daddr/dwdata/dwe and returns drdata combinationally in the same cycle.
- Provides word-organised RAM with byte-lane writes, plus a small MMIO window:
  - byte-stream TX FIFO with a valid/ready output for a console/UART,
  - status/control register,
  - free-running cycle counter (optional).

---
 rtl/dmem_mmio.sv | 143 ++++++++++++++
 tb/tb_dmem_mmio.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side slave with byte-lane word RAM and an MMIO window (TX FIFO, status/control).
// The cycle counter at 0x8000_0008 is present only when DMEM_CYCLE_CNT_EN is defined.
module dmem_mmio #(
    parameter int DEPTH      = 4096,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam logic [FW-1:0] PTR_ONE  = FW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    logic [31:0]   ram_r  [DEPTH];
    logic [7:0]    fifo_r [FIFO_DEPTH];
    logic [FW-1:0] wr_ptr_r;
    logic [FW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          ovf_r;

    logic          is_mmio_s;
    logic [3:0]    off_s;
    logic [AW-1:0] word_s;
    logic          push_req_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic          ovf_clr_s;
    logic [4:0]    count_ext_s;
    logic [31:0]   status_s;
    logic [31:0]   cycle_rd_s;
    logic          unused_addr_s;

    assign is_mmio_s     = daddr[31];
    assign off_s         = daddr[3:0];
    assign word_s        = daddr[AW+1:2];
    assign unused_addr_s = ^daddr[30:AW+2];

    assign tx_valid = ~empty_s;
    assign tx_data  = fifo_r[rd_ptr_r];

    // MMIO request decode and FIFO handshake qualification
    always_comb begin
        empty_s    = (count_r == {CW{1'b0}});
        full_s     = (count_r == CNT_FULL);
        push_req_s = is_mmio_s && (off_s == 4'h0) && dwe[0];
        ovf_clr_s  = is_mmio_s && (off_s == 4'h4) && dwe[0] && dwdata[8];
        pop_s      = ~empty_s && tx_ready;
        // A full FIFO still takes a byte when the head leaves in the same cycle
        push_s     = push_req_s && (~full_s || pop_s);
    end

    // Word RAM with independent byte-lane writes; never cleared
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!is_mmio_s && dwe[k]) begin
                ram_r[word_s][8*k +: 8] <= dwdata[8*k +: 8];
            end
        end
    end

    // FIFO byte storage; contents are meaningless while the slot is not counted
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_r[wr_ptr_r] <= dwdata[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {FW{1'b0}};
            rd_ptr_r <= {FW{1'b0}};
            count_r  <= {CW{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            // Setting overflow takes priority over a same-cycle clear
            if (push_req_s && full_s && !pop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] cycle_r;
    logic        cycle_wr_s;

    assign cycle_wr_s = is_mmio_s && (off_s == 4'h8) && (dwe != 4'b0000);
    assign cycle_rd_s = cycle_r;

    // Free-running cycle counter, loadable with a full word from the core
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_r <= 32'h0000_0000;
        end else if (cycle_wr_s) begin
            cycle_r <= dwdata;
        end else begin
            cycle_r <= cycle_r + 32'h0000_0001;
        end
    end
`else
    assign cycle_rd_s = 32'h0000_0000;
`endif

    // Combinational read path; reads have no side effects
    always_comb begin
        count_ext_s = 5'(count_r);
        status_s    = {23'h000000, ovf_r, count_ext_s, 1'b0, full_s, empty_s};
        if (!is_mmio_s) begin
            drdata = ram_r[word_s];
        end else begin
            case (off_s)
                4'h4:    drdata = status_s;
                4'h8:    drdata = cycle_rd_s;
                default: drdata = 32'h0000_0000;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed scenarios then randomized traffic, all checked against
// a queue/array reference model of the memory map.
module tb_dmem_mmio;
    localparam int DEPTH = 4096;
    localparam int FD    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram_m [int];
    logic [7:0]  q_m [$];
    logic        ovf_m = 1'b0;
    logic [31:0] cyc_m = 32'h0;

    always #5 clk = ~clk;

    dmem_mmio #(.DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
        .drdata(drdata), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_m();
        logic [31:0] s;
        int n;
        n = q_m.size();
        s = 32'h0;
        s[8]   = ovf_m;
        s[7:3] = 5'(n);
        s[1]   = (n == FD);
        s[0]   = (n == 0);
        return s;
    endfunction

    function automatic logic [31:0] mmio_m(input logic [3:0] off);
        case (off)
            4'h4: return status_m();
`ifdef DMEM_CYCLE_CNT_EN
            4'h8: return cyc_m;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_all(input string tag);
        int idx;
        idx = int'(daddr[13:2]);
        if (!daddr[31]) begin
            if (ram_m.exists(idx)) chk({tag, ":rd"}, drdata, ram_m[idx]);
        end else begin
            chk({tag, ":mmio"}, drdata, mmio_m(daddr[3:0]));
        end
        chk({tag, ":valid"}, {31'd0, tx_valid}, {31'd0, q_m.size() != 0});
        if (q_m.size() != 0) chk({tag, ":data"}, {24'd0, tx_data}, {24'd0, q_m[0]});
    endtask

    // Advance the model by the rules of the memory map using the inputs now applied.
    task automatic model_update();
        int idx;
        int n;
        logic [31:0] w;
        bit pop;
        idx = int'(daddr[13:2]);
        if (!daddr[31] && dwe != 4'h0 && (ram_m.exists(idx) || dwe == 4'hF)) begin
            w = ram_m.exists(idx) ? ram_m[idx] : 32'h0;
            for (int k = 0; k < 4; k++) if (dwe[k]) w[8*k +: 8] = dwdata[8*k +: 8];
            ram_m[idx] = w;
        end
        if (reset) begin
            q_m.delete();
            ovf_m = 1'b0;
            cyc_m = 32'h0;
        end else begin
            n = q_m.size();
            pop = (n != 0) && tx_ready;
            if (daddr[31] && daddr[3:0] == 4'h4 && dwe[0] && dwdata[8]) ovf_m = 1'b0;
            if (pop) void'(q_m.pop_front());
            if (daddr[31] && daddr[3:0] == 4'h0 && dwe[0]) begin
                if (n < FD || pop) q_m.push_back(dwdata[7:0]);
                else ovf_m = 1'b1;
            end
            if (daddr[31] && daddr[3:0] == 4'h8 && dwe != 4'h0) cyc_m = dwdata;
            else cyc_m = cyc_m + 32'h1;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                         input logic rdy);
        daddr = a; dwdata = wd; dwe = we; tx_ready = rdy;
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic rdy);
        drive(32'h8000_0000, {24'h0, b}, 4'h1, rdy);
        check_all("push");
        tick();
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        int op;
        reset = 1'b1;
        drive(32'h8000_0004, 32'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("reset_status", drdata, 32'h0000_0001);
        chk("reset_valid", {31'd0, tx_valid}, 32'h0);
        check_all("reset");

        // RAM lanes and same-cycle old-data read
        drive(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0); tick();
        drive(32'h0000_0100, 32'h1122_3344, 4'hF, 1'b0);
        chk("ram_old_data", drdata, 32'hDEAD_BEEF);
        tick();
        drive(32'h0000_0100, 32'h0000_AA00, 4'b0010, 1'b0);
        chk("ram_full_word", drdata, 32'h1122_3344);
        tick();
        drive(32'h0000_0100, 32'h0, 4'h0, 1'b0);
        chk("ram_lane", drdata, 32'h1122_AA44);
        drive(32'h4000_0100, 32'h0, 4'h0, 1'b0);
        chk("ram_alias", drdata, 32'h1122_AA44);

        // FIFO ordering and first-word latency
        push(8'h48, 1'b0);
        chk("fifo_first_valid", {31'd0, tx_valid}, 32'h1);
        chk("fifo_first_data", {24'd0, tx_data}, 32'h48);
        push(8'h69, 1'b0);
        drive(32'h8000_0004, 32'h0, 4'h0, 1'b0);
        chk("fifo_status2", drdata, 32'h0000_0010);
        tick();
        chk("fifo_hold", {24'd0, tx_data}, 32'h48);
        drive(32'h8000_0004, 32'h0, 4'h0, 1'b1);
        chk("fifo_out0", {24'd0, tx_data}, 32'h48);
        tick();
        chk("fifo_out1", {24'd0, tx_data}, 32'h69);
        tick();
        chk("fifo_drained_valid", {31'd0, tx_valid}, 32'h0);
        chk("fifo_drained_status", drdata, 32'h0000_0001);

        // Full and overflow
        for (int i = 1; i <= 8; i++) push(8'(i), 1'b0);
        drive(32'h8000_0004, 32'h0, 4'h0, 1'b0);
        chk("full_status", drdata, 32'h0000_0042);
        push(8'h09, 1'b0);
        drive(32'h8000_0004, 32'h0, 4'h0, 1'b0);
        chk("ovf_status", drdata, 32'h0000_0142);
        drive(32'h8000_0004, 32'h0000_0100, 4'h1, 1'b0); tick();
        drive(32'h8000_0004, 32'h0, 4'h0, 1'b0);
        chk("ovf_clear", drdata, 32'h0000_0042);
        for (int i = 1; i <= 8; i++) begin
            drive(32'h8000_0004, 32'h0, 4'h0, 1'b1);
            chk("drain_byte", {24'd0, tx_data}, 32'(i));
            tick();
        end
        chk("drain_empty", drdata, 32'h0000_0001);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 8; i++) push(8'(i), 1'b0);
        push(8'h55, 1'b1);
        drive(32'h8000_0004, 32'h0, 4'h0, 1'b0);
        chk("full_pushpop_status", drdata, 32'h0000_0042);
        for (int i = 2; i <= 9; i++) begin
            drive(32'h8000_0004, 32'h0, 4'h0, 1'b1);
            chk("pushpop_byte", {24'd0, tx_data}, (i == 9) ? 32'h55 : 32'(i));
            tick();
        end

        // Reset in the middle of a stream
        for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i), 1'b0);
        reset = 1'b1;
        drive(32'h8000_0004, 32'h0, 4'h0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk("midreset_valid", {31'd0, tx_valid}, 32'h0);
        chk("midreset_status", drdata, 32'h0000_0001);
        drive(32'h0000_0100, 32'h0, 4'h0, 1'b0);
        chk("midreset_ram", drdata, 32'h1122_AA44);

        // Cycle counter
        drive(32'h8000_0008, 32'hFFFF_FFFE, 4'h4, 1'b0); tick();
        drive(32'h8000_0008, 32'h0, 4'h0, 1'b0);
`ifdef DMEM_CYCLE_CNT_EN
        chk("cycle_load", drdata, 32'hFFFF_FFFE); tick();
        chk("cycle_max", drdata, 32'hFFFF_FFFF); tick();
        chk("cycle_wrap", drdata, 32'h0000_0000);
`else
        chk("cycle_absent0", drdata, 32'h0000_0000); tick();
        chk("cycle_absent1", drdata, 32'h0000_0000);
`endif
        drive(32'h8000_000C, 32'h0, 4'h0, 1'b0);
        chk("reserved_reg", drdata, 32'h0000_0000);

        // Randomized traffic over a small RAM window and the whole MMIO window
        for (int i = 0; i < 16; i++) begin
            drive(32'h0000_0100 + 32'(4 * i), $urandom, 4'hF, 1'b0);
            tick();
        end
        for (int c = 0; c < 600; c++) begin
            op = int'($urandom_range(0, 9));
            wd = $urandom;
            a  = $urandom;
            if (op < 3) begin
                a[31] = 1'b0;
                a[13:2] = 12'h040 + 12'($urandom_range(0, 15));
                drive(a, wd, (op == 0) ? 4'h0 : 4'($urandom), $urandom_range(0, 1) == 1);
            end else begin
                a[31] = 1'b1;
                if (op < 6) a[3:0] = 4'h0;
                else if (op < 8) a[3:0] = 4'h4;
                drive(a, wd, 4'($urandom), $urandom_range(0, 2) != 0);
            end
            reset = ($urandom_range(0, 60) == 0);
            #1;
            check_all("rand");
            tick();
            reset = 1'b0;
        end
        drive(32'h8000_0004, 32'h0, 4'h0, 1'b0);
        check_all("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
